// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath defaults, status-flag bit positions and opcodes.
`default_nettype none

package alu_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int RA_W_DEF  = 5;

   localparam int FLG_Z  = 0;
   localparam int FLG_N  = 1;
   localparam int FLG_V  = 2;
   localparam int FLG_SV = 3;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_SLT = 3'b101,
      OP_SLL = 3'b110,
      OP_SRL = 3'b111
   } alu_op_e;

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// Circular writeback FIFO holding {data, destination} pairs with occupancy tracking.
`default_nettype none

module wb_fifo import alu_pkg::*; #(
   parameter int WIDTH = WIDTH_DEF,
   parameter int RA_W  = RA_W_DEF,
   parameter int DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int LVL_W = PTR_W + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [RA_W-1:0]  wrd_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic [RA_W-1:0]  rrd_o,
   output logic [LVL_W-1:0] level_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [WIDTH-1:0] data_q [DEPTH];
   logic [RA_W-1:0]  rd_q   [DEPTH];
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             do_push, do_pop;

   assign full_o  = (level_q == LVL_W'(DEPTH));
   assign empty_o = (level_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
      end
   end

   // Storage is not reset; the read port is masked while empty instead.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         data_q[wptr_q] <= wdata_i;
         rd_q[wptr_q]   <= wrd_i;
      end
   end

   assign rdata_o = empty_o ? '0 : data_q[rptr_q];
   assign rrd_o   = empty_o ? '0 : rd_q[rptr_q];
   assign level_o = level_q;

endmodule

`default_nettype wire

// File: rtl/alu_wb_buffer.sv
// Buffers ALU results for register-file writeback and maintains status flags
// plus a saturating overflow counter.
`default_nettype none

module alu_wb_buffer import alu_pkg::*; #(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = 2,
   parameter int RA_W  = RA_W_DEF,
   parameter int CNT_W = 8
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     IN_VALID,
   output logic                     IN_READY,
   input  logic [WIDTH-1:0]         O_IN,
   input  logic                     OF_IN,
   input  logic [RA_W-1:0]          RD_IN,
   output logic                     OUT_VALID,
   input  logic                     OUT_READY,
   output logic [WIDTH-1:0]         WB_DATA,
   output logic [RA_W-1:0]          WB_RD,
   output logic [3:0]               FLAGS,
   input  logic                     CLR_SV,
   output logic [CNT_W-1:0]         OV_CNT,
   output logic [$clog2(DEPTH):0]   LEVEL
);

   logic             w_full, w_empty;
   logic             w_accept, w_push, w_pop;
   logic [3:0]       flags_q, flags_d;
   logic [CNT_W-1:0] ov_cnt_q, ov_cnt_d;

   assign IN_READY  = !RST && !w_full;
   assign OUT_VALID = !w_empty;
   assign w_accept  = IN_VALID && IN_READY;
   // Writes to register zero still update status but never occupy a slot.
   assign w_push    = w_accept && (RD_IN != '0);
   assign w_pop     = OUT_VALID && OUT_READY;

   wb_fifo #(
      .WIDTH (WIDTH),
      .RA_W  (RA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (CLK),
      .rst_i   (RST),
      .push_i  (w_push),
      .pop_i   (w_pop),
      .wdata_i (O_IN),
      .wrd_i   (RD_IN),
      .rdata_o (WB_DATA),
      .rrd_o   (WB_RD),
      .level_o (LEVEL),
      .full_o  (w_full),
      .empty_o (w_empty)
   );

   // Clear is applied first so a same-cycle overflow wins for SV and counts as 1.
   always_comb begin
      flags_d  = flags_q;
      ov_cnt_d = ov_cnt_q;
      if (CLR_SV) begin
         flags_d[FLG_SV] = 1'b0;
         ov_cnt_d        = '0;
      end
      if (w_accept) begin
         flags_d[FLG_Z] = (O_IN == '0);
         flags_d[FLG_N] = O_IN[WIDTH-1];
         flags_d[FLG_V] = OF_IN;
         if (OF_IN) begin
            flags_d[FLG_SV] = 1'b1;
            if (ov_cnt_d != '1) ov_cnt_d = ov_cnt_d + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         flags_q  <= '0;
         ov_cnt_q <= '0;
      end else begin
         flags_q  <= flags_d;
         ov_cnt_q <= ov_cnt_d;
      end
   end

   assign FLAGS  = flags_q;
   assign OV_CNT = ov_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_wb_buffer.sv
// Directed bench for alu_wb_buffer with a writeback scoreboard and status-flag model.
`default_nettype none

module tb_alu_wb_buffer;

   localparam int DEPTH = 2;

   logic        CLK = 1'b0;
   logic        RST;
   logic        IN_VALID;
   logic        IN_READY;
   logic [31:0] O_IN;
   logic        OF_IN;
   logic [4:0]  RD_IN;
   logic        OUT_VALID;
   logic        OUT_READY;
   logic [31:0] WB_DATA;
   logic [4:0]  WB_RD;
   logic [3:0]  FLAGS;
   logic        CLR_SV;
   logic [7:0]  OV_CNT;
   logic [1:0]  LEVEL;

   typedef struct {
      logic [31:0] d;
      logic [4:0]  rd;
   } wb_t;

   wb_t        sb[$];
   logic [3:0] exp_flags = '0;
   logic [7:0] exp_cnt   = '0;
   int         n_checks  = 0;
   int         n_fail    = 0;

   alu_wb_buffer #(.WIDTH(32), .DEPTH(DEPTH), .RA_W(5), .CNT_W(8)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .O_IN      (O_IN),
      .OF_IN     (OF_IN),
      .RD_IN     (RD_IN),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .WB_DATA   (WB_DATA),
      .WB_RD     (WB_RD),
      .FLAGS     (FLAGS),
      .CLR_SV    (CLR_SV),
      .OV_CNT    (OV_CNT),
      .LEVEL     (LEVEL)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, compare pre-edge outputs with the model, advance the model.
   task automatic cycle(input logic iv, input logic [31:0] o, input logic of,
                        input logic [4:0] rd, input logic ordy, input logic clr);
      logic acc;
      IN_VALID  = iv;
      O_IN      = o;
      OF_IN     = of;
      RD_IN     = rd;
      OUT_READY = ordy;
      CLR_SV    = clr;
      #1;
      check("in_ready",  IN_READY,  sb.size() < DEPTH);
      check("out_valid", OUT_VALID, sb.size() != 0);
      check("level",     LEVEL,     sb.size());
      check("flags",     FLAGS,     exp_flags);
      check("ov_cnt",    OV_CNT,    exp_cnt);
      if (sb.size() > 0) begin
         check("wb_data", WB_DATA, sb[0].d);
         check("wb_rd",   WB_RD,   sb[0].rd);
      end
      acc = iv && (sb.size() < DEPTH);
      if (ordy && sb.size() > 0) void'(sb.pop_front());
      if (acc && rd != 5'd0) sb.push_back('{d: o, rd: rd});
      if (clr) begin
         exp_flags[3] = 1'b0;
         exp_cnt      = 8'd0;
      end
      if (acc) begin
         exp_flags[0] = (o == 32'd0);
         exp_flags[1] = o[31];
         exp_flags[2] = of;
         if (of) begin
            exp_flags[3] = 1'b1;
            if (exp_cnt != 8'd255) exp_cnt = exp_cnt + 8'd1;
         end
      end
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RST = 1'b1; IN_VALID = 1'b0; O_IN = '0; OF_IN = 1'b0; RD_IN = '0;
      OUT_READY = 1'b0; CLR_SV = 1'b0;
      #1;
      check("rst_in_ready",  IN_READY,  1'b0);
      check("rst_out_valid", OUT_VALID, 1'b0);
      check("rst_level",     LEVEL,     2'd0);
      check("rst_flags",     FLAGS,     4'd0);
      check("rst_ov_cnt",    OV_CNT,    8'd0);
      check("rst_wb_data",   WB_DATA,   32'd0);
      check("rst_wb_rd",     WB_RD,     5'd0);
      @(negedge CLK);
      RST = 1'b0;
      @(posedge CLK);
      #1;

      // Zero result to r3
      cycle(1'b1, 32'h0000_0000, 1'b0, 5'd3, 1'b0, 1'b0);
      check("t1_out_valid", OUT_VALID, 1'b1);
      check("t1_wb_data",   WB_DATA,   32'd0);
      check("t1_wb_rd",     WB_RD,     5'd3);
      check("t1_flags",     FLAGS,     4'b0001);

      // Overflowing result to r5 fills the buffer
      cycle(1'b1, 32'h8000_0000, 1'b1, 5'd5, 1'b0, 1'b0);
      check("t2_flags",    FLAGS,    4'b1110);
      check("t2_ov_cnt",   OV_CNT,   8'd1);
      check("t2_in_ready", IN_READY, 1'b0);
      check("t2_level",    LEVEL,    2'd2);
      // Third request while full must be ignored
      cycle(1'b1, 32'h0000_1234, 1'b0, 5'd7, 1'b0, 1'b0);
      check("t3_flags_held", FLAGS, 4'b1110);
      cycle(1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
      cycle(1'b0, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0);
      check("t3_in_ready_after_pop", IN_READY, 1'b1);
      check("t3_head_rd",            WB_RD,    5'd5);
      cycle(1'b0, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0);
      check("t3_drained", OUT_VALID, 1'b0);

      // Steady stream at LEVEL=1
      cycle(1'b1, 32'd100, 1'b0, 5'd1, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 32'd200 + 32'(i), 1'b0, 5'((i % 31) + 2), 1'b1, 1'b0);
         check("stream_level", LEVEL, 2'd1);
      end
      cycle(1'b0, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0);

      // Discarded write to r0 still sets flags
      cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 5'd0, 1'b0, 1'b0);
      check("r0_out_valid", OUT_VALID, 1'b0);
      check("r0_flags_n",   FLAGS[1],  1'b1);
      check("r0_flags_z",   FLAGS[0],  1'b0);

      // Clear coincident with overflow: set wins
      cycle(1'b1, 32'h0000_0001, 1'b1, 5'd0, 1'b0, 1'b1);
      check("clr_of_sv",  FLAGS[3], 1'b1);
      check("clr_of_cnt", OV_CNT,   8'd1);
      cycle(1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b1);
      check("clr_sv",  FLAGS[3], 1'b0);
      check("clr_cnt", OV_CNT,   8'd0);

      // Counter saturation
      for (int i = 0; i < 300; i++) cycle(1'b1, 32'h0000_0010, 1'b1, 5'd0, 1'b0, 1'b0);
      check("ov_cnt_sat", OV_CNT, 8'd255);

      // Asynchronous reset with two entries buffered
      cycle(1'b1, 32'hAAAA_0001, 1'b0, 5'd9,  1'b0, 1'b0);
      cycle(1'b1, 32'hAAAA_0002, 1'b0, 5'd10, 1'b0, 1'b0);
      check("pre_rst_level", LEVEL, 2'd2);
      #2;
      RST = 1'b1;
      #1;
      check("arst_out_valid", OUT_VALID, 1'b0);
      check("arst_level",     LEVEL,     2'd0);
      check("arst_flags",     FLAGS,     4'd0);
      check("arst_ov_cnt",    OV_CNT,    8'd0);
      check("arst_in_ready",  IN_READY,  1'b0);
      check("arst_wb_data",   WB_DATA,   32'd0);
      sb.delete();
      exp_flags = '0;
      exp_cnt   = '0;
      IN_VALID  = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
      @(posedge CLK);
      #1;
      for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
